// File: rtl/pag_refill_ctl.sv
// Page-refill sequencer for the MBox paging board: checks the page table lookup, refills a
// missing entry from the user/exec process table in core, and reports page OK or a held fail.
module pag_refill_ctl #(
  parameter int unsigned MAX_REFILL = 1
) (
  input  logic        clk,
  input  logic        reset_h,
  input  logic        ebox_req_h,
  input  logic        vma_user_h,
  input  logic        vma_write_h,
  input  logic [8:0]  vma_page_h,
  input  logic [12:0] ubr_h,
  input  logic [12:0] ebr_h,
  input  logic        pt_match_h,
  input  logic        pt_access_h,
  input  logic        pt_writable_h,
  output logic        mem_req_h,
  output logic [21:0] mem_adr_h,
  input  logic        mem_ack_h,
  input  logic        mem_data_valid_h,
  input  logic [35:0] mem_data_h,
  input  logic        mem_par_err_h,
  output logic        pt_wr_h,
  output logic        pt_dir_wr_h,
  output logic [17:0] pt_wr_data_h,
  output logic        refill_busy_h,
  output logic        page_ok_h,
  output logic        page_fail_h,
  output logic [4:0]  pf_code_h,
  input  logic        pf_clear_h
);

  localparam int unsigned CntW = (MAX_REFILL < 1) ? 1 : $clog2(MAX_REFILL + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_REFILL);

  localparam logic [4:0] CodeNoAccess = 5'o21;
  localparam logic [4:0] CodeWrProt   = 5'o12;
  localparam logic [4:0] CodeIllegal  = 5'o25;
  localparam logic [4:0] CodeParity   = 5'o36;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StReq,
    StWait,
    StWrite,
    StFail
  } state_e;

  state_e          state_q;
  logic            user_q;
  logic            write_q;
  logic [8:0]      page_q;
  logic [CntW-1:0] refill_cnt_q;
  logic [17:0]     half_word;

  // Word bit 0 is the MSB, so the left half (bits 0-17) sits in mem_data_h[35:18].
  assign half_word = page_q[0] ? mem_data_h[17:0] : mem_data_h[35:18];

  always_ff @(posedge clk) begin
    if (reset_h) begin
      state_q       <= StIdle;
      user_q        <= 1'b0;
      write_q       <= 1'b0;
      page_q        <= '0;
      refill_cnt_q  <= '0;
      mem_req_h     <= 1'b0;
      mem_adr_h     <= '0;
      pt_wr_h       <= 1'b0;
      pt_dir_wr_h   <= 1'b0;
      pt_wr_data_h  <= '0;
      refill_busy_h <= 1'b0;
      page_ok_h     <= 1'b0;
      page_fail_h   <= 1'b0;
      pf_code_h     <= '0;
    end else begin
      page_ok_h   <= 1'b0;
      pt_wr_h     <= 1'b0;
      pt_dir_wr_h <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ebox_req_h) begin
            user_q       <= vma_user_h;
            write_q      <= vma_write_h;
            page_q       <= vma_page_h;
            refill_cnt_q <= '0;
            state_q      <= StLookup;
          end
        end
        StLookup: begin
          if (pt_match_h) begin
            if (!pt_access_h) begin
              page_fail_h <= 1'b1;
              pf_code_h   <= CodeNoAccess;
              state_q     <= StFail;
            end else if (write_q && !pt_writable_h) begin
              page_fail_h <= 1'b1;
              pf_code_h   <= CodeWrProt;
              state_q     <= StFail;
            end else begin
              page_ok_h <= 1'b1;
              state_q   <= StIdle;
            end
          end else if (refill_cnt_q < MaxCnt) begin
            mem_req_h     <= 1'b1;
            mem_adr_h     <= user_q ? {ubr_h, 1'b0, page_q[8:1]} : {ebr_h, 1'b1, page_q[8:1]};
            refill_busy_h <= 1'b1;
            state_q       <= StReq;
          end else begin
            page_fail_h <= 1'b1;
            pf_code_h   <= CodeIllegal;
            state_q     <= StFail;
          end
        end
        StReq: begin
          // Data arriving with the ack is dropped; memory must present it again in WAIT.
          if (mem_ack_h) begin
            mem_req_h <= 1'b0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (mem_data_valid_h) begin
            if (mem_par_err_h) begin
              refill_busy_h <= 1'b0;
              page_fail_h   <= 1'b1;
              pf_code_h     <= CodeParity;
              state_q       <= StFail;
            end else if (!half_word[17]) begin
              refill_busy_h <= 1'b0;
              page_fail_h   <= 1'b1;
              pf_code_h     <= CodeNoAccess;
              state_q       <= StFail;
            end else begin
              pt_wr_data_h <= half_word;
              pt_wr_h      <= 1'b1;
              pt_dir_wr_h  <= 1'b1;
              state_q      <= StWrite;
            end
          end
        end
        StWrite: begin
          refill_cnt_q  <= refill_cnt_q + CntW'(1);
          refill_busy_h <= 1'b0;
          state_q       <= StLookup;
        end
        StFail: begin
          if (pf_clear_h) begin
            page_fail_h <= 1'b0;
            pf_code_h   <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
